// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: opcodes, forwarding selects, FSM states.
package hazard_ctrl_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BRA   = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_MEM_WAIT = 2'b01,
    HZ_FLUSH    = 2'b10
  } hz_state_e;

  function automatic logic op_uses_rs1(input logic [6:0] op);
    case (op)
      OP_JALR, OP_BRA, OP_LOAD, OP_STORE, OP_ALUI, OP_ALU: op_uses_rs1 = 1'b1;
      default:                                             op_uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic op_uses_rs2(input logic [6:0] op);
    case (op)
      OP_BRA, OP_STORE, OP_ALU: op_uses_rs2 = 1'b1;
      default:                  op_uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational EX operand forwarding selects and WB-to-ID bypass bits.
module hazard_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       uses_rs1,
  input  logic       uses_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [1:0] id_wb_bypass
);

  logic mem_valid, wb_valid;

  assign mem_valid = mem_regwrite && (mem_rd != 5'd0);
  assign wb_valid  = wb_regwrite && (wb_rd != 5'd0);

  // EX/MEM is younger than MEM/WB, so it wins when both match
  always_comb begin
    fwd_a = FWD_REG;
    if (mem_valid && (mem_rd == ex_rs1))     fwd_a = FWD_EXMEM;
    else if (wb_valid && (wb_rd == ex_rs1))  fwd_a = FWD_MEMWB;
    fwd_b = FWD_REG;
    if (mem_valid && (mem_rd == ex_rs2))     fwd_b = FWD_EXMEM;
    else if (wb_valid && (wb_rd == ex_rs2))  fwd_b = FWD_MEMWB;
  end

  // ID reads the regfile in the same cycle WB writes it
  always_comb begin
    id_wb_bypass[1] = wb_valid && uses_rs1 && (wb_rd == id_rs1);
    id_wb_bypass[0] = wb_valid && uses_rs2 && (wb_rd == id_rs2);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, dmem wait freeze, counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             if_keep,
  output logic             id_keep,
  output logic             id_nop,
  output logic             if_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       id_wb_bypass,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [15:0]      flush_cnt,
  output logic [1:0]       state
);

  localparam logic [2:0] FlushReload = 3'(FLUSH_CYCLES - 1);

  hz_state_e        state_q, state_d;
  logic [2:0]       flush_left_q, flush_left_d;
  logic             pend_flush_q, pend_flush_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [15:0]      flush_cnt_q, flush_cnt_d;

  logic uses_rs1, uses_rs2, load_use, mem_stall, flush_evt;
  logic [1:0] fwd_a_raw, fwd_b_raw, bypass_raw;

  assign uses_rs1  = op_uses_rs1(id_opcode);
  assign uses_rs2  = op_uses_rs2(id_opcode);
  assign load_use  = ex_is_load && ex_regwrite && (ex_rd != 5'd0) &&
                     ((uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd)));
  assign mem_stall = dmem_req && !dmem_ready;
  // A branch held back by a freeze is replayed through pend_flush
  assign flush_evt = ex_branch_taken || pend_flush_q;

  hazard_fwd_unit u_fwd (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .uses_rs1     (uses_rs1),
    .uses_rs2     (uses_rs2),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw),
    .id_wb_bypass (bypass_raw)
  );

  // State register and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HZ_RUN;
      flush_left_q <= 3'd0;
      pend_flush_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      pend_flush_q <= pend_flush_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Next-state: freeze > flush event > flush countdown > run
  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    pend_flush_d = pend_flush_q;
    flush_cnt_d  = flush_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (if_keep && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (mem_stall) begin
      // A freeze during FLUSH keeps the remaining flush cycles for later
      state_d = (state_q == HZ_FLUSH) ? HZ_FLUSH : HZ_MEM_WAIT;
      if (ex_branch_taken) pend_flush_d = 1'b1;
    end else if (flush_evt) begin
      pend_flush_d = 1'b0;
      if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
      if (FLUSH_CYCLES > 1) begin
        flush_left_d = FlushReload;
        state_d      = HZ_FLUSH;
      end else begin
        flush_left_d = 3'd0;
        state_d      = HZ_RUN;
      end
    end else if (state_q == HZ_FLUSH) begin
      if (flush_left_q != 3'd0) flush_left_d = flush_left_q - 3'd1;
      if (flush_left_q <= 3'd1) state_d = HZ_RUN;
    end else begin
      state_d = HZ_RUN;
    end
  end

  // Pipeline controls, combinational from state and current inputs
  always_comb begin
    if_keep  = 1'b0;
    id_keep  = 1'b0;
    id_nop   = 1'b0;
    if_flush = 1'b0;
    if (rst) begin
      id_nop   = 1'b1;
      if_flush = 1'b1;
    end else if (mem_stall) begin
      if_keep = 1'b1;
      id_keep = 1'b1;
    end else if (flush_evt || (state_q == HZ_FLUSH)) begin
      id_nop   = 1'b1;
      if_flush = 1'b1;
    end else if (load_use) begin
      id_nop  = 1'b1;
      if_keep = 1'b1;
    end
  end

  assign fwd_a        = rst ? FWD_REG : fwd_a_raw;
  assign fwd_b        = rst ? FWD_REG : fwd_b_raw;
  assign id_wb_bypass = rst ? 2'b00 : bypass_raw;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign state        = state_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline controller for the 5-stage core. Each cycle it produces the keep/nop controls that sequence the decode stage and the keep/flush controls for fetch. It detects load-use hazards, taken-branch flushes and data-memory wait stalls. It also drives the EX operand forwarding selects, the WB-to-ID bypass bits, and stall/flush performance counters.

Parameters:
FLUSH_CYCLES, 1, cycles if_flush stays asserted per taken branch (1..7); covers multi-cycle imem latency
CNT_W, 32, width of stall_cnt; saturating

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_opcode  in  7  opcode of instruction in ID
id_rs1  in  5  ID source reg 1
id_rs2  in  5  ID source reg 2
ex_rs1  in  5  rs1 held in ID/EX
ex_rs2  in  5  rs2 held in ID/EX
ex_rd  in  5  ID/EX destination
ex_regwrite  in  1  ID/EX RegWrite
ex_is_load  in  1  ID/EX MemtoReg selects memory data
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_rd  in  5  EX/MEM destination
mem_regwrite  in  1  EX/MEM RegWrite
wb_rd  in  5  MEM/WB destination
wb_regwrite  in  1  MEM/WB RegWrite
dmem_req  in  1  MEM stage has an outstanding load/store
dmem_ready  in  1  data memory completes this cycle
if_keep  out  1  hold PC and IF/ID register
id_keep  out  1  decode keep (hold ID/EX)
id_nop  out  1  decode nop (bubble into ID/EX; overrides keep)
if_flush  out  1  squash IF/ID contents
fwd_a  out  2  EX operand A: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b  out  2  EX operand B, same encoding
id_wb_bypass  out  2  [1] rs1 / [0] rs2 take WB write data in ID
stall_cnt  out  CNT_W  cycles with if_keep=1
flush_cnt  out  16  taken-branch flush events
state  out  2  FSM state, for debug

Behaviour:
- FSM states: RUN=00, MEM_WAIT=01, FLUSH=10. Registers: state, flush_left (3b), pend_flush (1b), and both counters.
- Reset (rst=1 at clk edge): state=RUN, flush_left=0, pend_flush=0, counters=0. While rst=1, outputs are id_nop=1, if_flush=1, if_keep=0, id_keep=0, fwd_a=fwd_b=00, id_wb_bypass=00. Reset mid-stall or mid-flush drops all pending work.
- uses_rs1/uses_rs2 are decoded from id_opcode. uses_rs1 for JALR, BRA, LOAD, STORE, ALUI, ALU. uses_rs2 for BRA, STORE, ALU. Neither for LUI, AUIPC, JAL or unknown opcodes.
- load_use = ex_is_load & ex_regwrite & ex_rd!=0 & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)).
- mem_stall = dmem_req & !dmem_ready.
- Control outputs are combinational from state and current inputs. Priority per cycle:
  1. mem_stall: if_keep=1, id_keep=1, id_nop=0, if_flush=0; next state MEM_WAIT. If ex_branch_taken, set pend_flush=1.
  2. ex_branch_taken, or pend_flush with !mem_stall: id_nop=1, if_flush=1, if_keep=0. flush_cnt+1 (saturating). Clear pend_flush. If FLUSH_CYCLES>1: flush_left=FLUSH_CYCLES-1, next state FLUSH; otherwise stay in RUN. A branch overrides a simultaneous load_use, because the hazarding instruction is squashed.
  3. load_use: id_nop=1, if_keep=1, id_keep=0, if_flush=0; single bubble, stay in RUN.
  4. Otherwise all four controls are 0.
- MEM_WAIT: return to RUN in the cycle dmem_ready=1. Controls in that cycle follow priorities 2–4 (pend_flush is honoured there).
- FLUSH: if_flush=1, id_nop=1; flush_left decrements each cycle; go to RUN after the cycle with flush_left==1. If mem_stall occurs in FLUSH, the freeze (priority 1) wins and flush_left holds. A new ex_branch_taken in FLUSH reloads flush_left.
- Forwarding, fwd_a (fwd_b identical using ex_rs2):
  - 01 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1
  - else 10 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1
  - else 00
  - EX/MEM wins over MEM/WB.
- id_wb_bypass[1] = wb_regwrite & wb_rd!=0 & wb_rd==id_rs1 & uses_rs1. Bit [0] is the same with id_rs2 and uses_rs2.
- Register x0 never causes forwarding, a bypass or a stall.
- stall_cnt increments every cycle if_keep=1 and saturates at all-ones. flush_cnt counts priority-2 events and saturates at 16'hFFFF.

Decomposition:
- Shared package/define file gets the OP_* opcodes (existing), the FWD_REG/FWD_EXMEM/FWD_MEMWB encodings and the HZ_RUN/HZ_MEM_WAIT/HZ_FLUSH state codes.
- One natural sub-module, hazard_fwd_unit: purely combinational fwd_a/fwd_b/id_wb_bypass; the FSM and counters stay in hazard_ctrl.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, ex_regwrite=1, id_opcode=ALU, id_rs2=5 -> id_nop=1, if_keep=1 for exactly one cycle; stall_cnt=1.
- Forward priority: mem_rd=wb_rd=ex_rs1=7, both regwrite=1 -> fwd_a=01. Then mem_regwrite=0 -> fwd_a=10. With ex_rs1=0 and rd=0 -> fwd_a=00.
- Branch flush, FLUSH_CYCLES=3: ex_branch_taken pulse -> if_flush=1 and id_nop=1 for 3 cycles, state RUN→FLUSH→FLUSH→RUN, flush_cnt=1.
- Mem wait plus branch: dmem_req=1, dmem_ready=0 for 4 cycles with ex_branch_taken=1 -> if_keep=id_keep=1 for 4 cycles, no flush. The cycle dmem_ready=1 gives id_nop=1 and if_flush=1; stall_cnt=4.
- Branch with simultaneous load_use -> flush behaviour only; if_keep=0.
- Reset mid-FLUSH: rst=1 one cycle -> state=RUN, counters=0, id_nop=1 and if_flush=1 during reset; the next cycle with no hazard has all controls at 0.
